stack_op_sequencer: RTL and testbench

- Multi-cycle operation sequencer that sits directly in front of the 8-bit, 32-entry Stack block. It drives that block's push, pop and tos strobes and its data input, and consumes its registered output.
- It accepts one opcode at a time (PUSH, POP, TOP, ADD, SUB, AND, NOT, DUP) and breaks it into the required stack accesses.
- It tracks stack depth for underflow and overflow checking.
- It returns the op result with a one-cycle done pulse.

---
 rtl/stack_op_sequencer.sv | 136 +++++++++++++
 tb/tb_stack_op_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_op_sequencer.sv
// Multi-cycle opcode sequencer in front of a registered-output LIFO stack.
// Breaks each opcode into pop/tos/push strobes and tracks depth for bound checks.
module stack_op_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned DW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] stk_dout,
    output logic             stk_push,
    output logic             stk_pop,
    output logic             stk_tos,
    output logic [WIDTH-1:0] stk_din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [DW-1:0]    depth
);

    localparam logic [2:0] OpPush = 3'b000;
    localparam logic [2:0] OpPop  = 3'b001;
    localparam logic [2:0] OpTop  = 3'b010;
    localparam logic [2:0] OpAdd  = 3'b011;
    localparam logic [2:0] OpSub  = 3'b100;
    localparam logic [2:0] OpAnd  = 3'b101;
    localparam logic [2:0] OpNot  = 3'b110;
    localparam logic [2:0] OpDup  = 3'b111;

    typedef enum logic [2:0] {
        StIdle, StChk, StRdA, StLatA, StRdB, StLatB, StWr, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q, result_q, wr_val;
    logic [DW-1:0]    depth_q;
    logic             err_q, chk_err;

    // Operand underflow and capacity overflow, evaluated against the latched opcode.
    always_comb begin
        chk_err = 1'b0;
        unique case (op_q)
            OpPush:                chk_err = (depth_q == DW'(DEPTH));
            OpPop, OpTop, OpNot:   chk_err = (depth_q == '0);
            OpDup:                 chk_err = (depth_q == '0) || (depth_q == DW'(DEPTH));
            OpAdd, OpSub, OpAnd:   chk_err = (depth_q < DW'(2));
            default:               chk_err = 1'b0;
        endcase
    end

    always_comb begin
        wr_val = '0;
        unique case (op_q)
            OpPush:  wr_val = imm_q;
            OpNot:   wr_val = ~a_q;
            OpDup:   wr_val = a_q;
            OpAdd:   wr_val = b_q + a_q;
            OpSub:   wr_val = b_q - a_q;
            OpAnd:   wr_val = b_q & a_q;
            default: wr_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StChk;
            StChk: begin
                if (chk_err)              state_d = StDone;
                else if (op_q == OpPush)  state_d = StWr;
                else                      state_d = StRdA;
            end
            StRdA: state_d = StLatA;
            StLatA: begin
                if (op_q == OpPop || op_q == OpTop)      state_d = StDone;
                else if (op_q == OpNot || op_q == OpDup) state_d = StWr;
                else                                     state_d = StRdB;
            end
            StRdB:   state_d = StLatB;
            StLatB:  state_d = StWr;
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stk_push = (state_q == StWr);
        stk_tos  = (state_q == StRdA) && (op_q == OpTop || op_q == OpDup);
        stk_pop  = ((state_q == StRdA) && !(op_q == OpTop || op_q == OpDup))
                   || (state_q == StRdB);
        stk_din  = stk_push ? wr_val : '0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        err      = done && err_q;
        result   = result_q;
        zero     = (result_q == '0);
        depth    = depth_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpPush;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            depth_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && start) begin
                op_q  <= opcode;
                imm_q <= imm;
                err_q <= 1'b0;
            end
            if (state_q == StChk) err_q <= chk_err;
            if (state_q == StLatA) begin
                a_q <= stk_dout;
                if (op_q == OpPop || op_q == OpTop) result_q <= stk_dout;
            end
            if (state_q == StLatB) b_q <= stk_dout;
            if (state_q == StWr) result_q <= wr_val;
            if (stk_push)     depth_q <= depth_q + DW'(1);
            else if (stk_pop) depth_q <= depth_q - DW'(1);
        end
    end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench: sequencer driving a behavioural registered-output stack model.
module tb_stack_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [7:0] imm = 8'h00;
    logic [7:0] stk_dout;
    logic       stk_push, stk_pop, stk_tos, busy, done, err, zero;
    logic [7:0] stk_din, result;
    logic [5:0] depth;

    int n_checks = 0;
    int n_fail = 0;

    stack_op_sequencer #(.WIDTH(8), .DEPTH(32), .DW(6)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .imm(imm),
        .stk_dout(stk_dout), .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
        .stk_din(stk_din), .busy(busy), .done(done), .err(err), .result(result),
        .zero(zero), .depth(depth)
    );

    always #5 clk = ~clk;

    // Stack model: pop/tos data appears on stk_dout the cycle after the strobe.
    logic [7:0] mem [0:31];
    int         sp = 0;
    always @(posedge clk) begin
        if (rst) begin
            sp <= 0;
            stk_dout <= 8'h00;
        end else if (stk_push && sp < 32) begin
            mem[sp] <= stk_din;
            sp <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp <= sp - 1;
        end else if (stk_tos && sp > 0) begin
            stk_dout <= mem[sp-1];
        end
    end

    // Running strobe/done totals, sampled mid-cycle.
    int tot_push = 0, tot_pop = 0, tot_tos = 0, tot_done = 0, tot_multi = 0;
    logic [7:0] last_din = 8'h00;
    always @(negedge clk) begin
        if (stk_push) begin
            tot_push <= tot_push + 1;
            last_din <= stk_din;
        end
        if (stk_pop)  tot_pop  <= tot_pop + 1;
        if (stk_tos)  tot_tos  <= tot_tos + 1;
        if (done)     tot_done <= tot_done + 1;
        if (32'(stk_push) + 32'(stk_pop) + 32'(stk_tos) > 1) tot_multi <= tot_multi + 1;
    end

    int         lat, n_push, n_pop, n_tos;
    logic       r_err;
    logic [7:0] r_res;
    logic [5:0] r_dep;

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one op and waits (bounded) for done; lat = 99 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [7:0] val);
        int p0, q0, t0;
        p0 = tot_push; q0 = tot_pop; t0 = tot_tos;
        start = 1'b1; opcode = op; imm = val;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 99;
        r_err = err; r_res = result; r_dep = depth;
        @(negedge clk);
        n_push = tot_push - p0; n_pop = tot_pop - q0; n_tos = tot_tos - t0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({stk_push, stk_pop, stk_tos, busy, done, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {stk_push, stk_pop, stk_tos, busy, done, err});
        end
        n_checks++;
        if (stk_din !== 8'h00 || result !== 8'h00 || zero !== 1'b1 || depth !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_data: din=%h res=%h zero=%b depth=%0d want 00 00 1 0",
                     stk_din, result, zero, depth);
        end
    endtask

    task automatic test_push();
        do_reset();
        run_op(3'b000, 8'h05);
        n_checks++;
        if (lat !== 3 || n_push !== 1 || last_din !== 8'h05) begin
            n_fail++;
            $display("FAIL push_timing: lat=%0d pushes=%0d din=%h want 3 1 05",
                     lat, n_push, last_din);
        end
        n_checks++;
        if (r_res !== 8'h05 || zero !== 1'b0 || r_dep !== 6'd1 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL push_result: res=%h zero=%b depth=%0d err=%b want 05 0 1 0",
                     r_res, zero, r_dep, r_err);
        end
    endtask

    task automatic test_sub();
        do_reset();
        run_op(3'b000, 8'h0A);
        run_op(3'b000, 8'h03);
        run_op(3'b100, 8'h00);
        n_checks++;
        if (lat !== 7 || n_pop !== 2 || n_push !== 1 || last_din !== 8'h07) begin
            n_fail++;
            $display("FAIL sub_seq: lat=%0d pops=%0d pushes=%0d din=%h want 7 2 1 07",
                     lat, n_pop, n_push, last_din);
        end
        n_checks++;
        if (r_res !== 8'h07 || r_dep !== 6'd1 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_result: res=%h depth=%0d err=%b want 07 1 0", r_res, r_dep, r_err);
        end
    endtask

    task automatic test_add_and();
        do_reset();
        run_op(3'b000, 8'hF0);
        run_op(3'b000, 8'h20);
        run_op(3'b011, 8'h00);
        n_checks++;
        if (r_res !== 8'h10 || last_din !== 8'h10 || r_dep !== 6'd1) begin
            n_fail++;
            $display("FAIL add_wrap: res=%h din=%h depth=%0d want 10 10 1", r_res, last_din, r_dep);
        end
        run_op(3'b000, 8'h0F);
        run_op(3'b000, 8'hF0);
        run_op(3'b101, 8'h00);
        n_checks++;
        if (r_res !== 8'h00 || zero !== 1'b1 || r_dep !== 6'd2 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL and_zero: res=%h zero=%b depth=%0d err=%b want 00 1 2 0",
                     r_res, zero, r_dep, r_err);
        end
    endtask

    task automatic test_unary();
        do_reset();
        run_op(3'b000, 8'h11);
        run_op(3'b000, 8'h3C);
        run_op(3'b110, 8'h00);
        n_checks++;
        if (lat !== 5 || r_res !== 8'hC3 || n_pop !== 1 || n_push !== 1 || r_dep !== 6'd2) begin
            n_fail++;
            $display("FAIL not_op: lat=%0d res=%h pops=%0d pushes=%0d depth=%0d want 5 c3 1 1 2",
                     lat, r_res, n_pop, n_push, r_dep);
        end
        run_op(3'b111, 8'h00);
        n_checks++;
        if (lat !== 5 || last_din !== 8'hC3 || n_tos !== 1 || n_pop !== 0 || r_dep !== 6'd3) begin
            n_fail++;
            $display("FAIL dup_op: lat=%0d din=%h tos=%0d pops=%0d depth=%0d want 5 c3 1 0 3",
                     lat, last_din, n_tos, n_pop, r_dep);
        end
        run_op(3'b001, 8'h00);
        run_op(3'b001, 8'h00);
        n_checks++;
        if (lat !== 4 || r_res !== 8'hC3 || r_dep !== 6'd1) begin
            n_fail++;
            $display("FAIL pop_op: lat=%0d res=%h depth=%0d want 4 c3 1", lat, r_res, r_dep);
        end
        run_op(3'b010, 8'h00);
        n_checks++;
        if (lat !== 4 || r_res !== 8'h11 || r_dep !== 6'd1 || n_tos !== 1 || n_pop !== 0) begin
            n_fail++;
            $display("FAIL top_op: lat=%0d res=%h depth=%0d tos=%0d pops=%0d want 4 11 1 1 0",
                     lat, r_res, r_dep, n_tos, n_pop);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        run_op(3'b001, 8'h00);
        n_checks++;
        if (r_err !== 1'b1 || lat !== 2 || n_pop + n_push + n_tos !== 0 || r_dep !== 6'd0
            || r_res !== 8'h00) begin
            n_fail++;
            $display("FAIL pop_underflow: err=%b lat=%0d strobes=%0d depth=%0d res=%h want 1 2 0 0 00",
                     r_err, lat, n_pop + n_push + n_tos, r_dep, r_res);
        end
        run_op(3'b000, 8'h42);
        run_op(3'b011, 8'h00);
        n_checks++;
        if (r_err !== 1'b1 || n_pop + n_push + n_tos !== 0 || r_dep !== 6'd1 || r_res !== 8'h42) begin
            n_fail++;
            $display("FAIL add_underflow: err=%b strobes=%0d depth=%0d res=%h want 1 0 1 42",
                     r_err, n_pop + n_push + n_tos, r_dep, r_res);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 32; i++) run_op(3'b000, 8'(i + 1));
        n_checks++;
        if (r_dep !== 6'd32 || r_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: depth=%0d err=%b want 32 0", r_dep, r_err);
        end
        run_op(3'b000, 8'h99);
        n_checks++;
        if (r_err !== 1'b1 || n_push !== 0 || r_dep !== 6'd32 || r_res !== 8'h20) begin
            n_fail++;
            $display("FAIL push_overflow: err=%b pushes=%0d depth=%0d res=%h want 1 0 32 20",
                     r_err, n_push, r_dep, r_res);
        end
        run_op(3'b111, 8'h00);
        n_checks++;
        if (r_err !== 1'b1 || n_push + n_tos !== 0 || r_dep !== 6'd32) begin
            n_fail++;
            $display("FAIL dup_overflow: err=%b strobes=%0d depth=%0d want 1 0 32",
                     r_err, n_push + n_tos, r_dep);
        end
        run_op(3'b001, 8'h00);
        n_checks++;
        if (r_err !== 1'b0 || r_res !== 8'h20 || r_dep !== 6'd31) begin
            n_fail++;
            $display("FAIL pop_after_full: err=%b res=%h depth=%0d want 0 20 31", r_err, r_res, r_dep);
        end
    endtask

    task automatic test_midop_reset_and_busy_start();
        int d0, p0;
        do_reset();
        run_op(3'b000, 8'h01);
        run_op(3'b000, 8'h02);
        start = 1'b1; opcode = 3'b011;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        // Now in the second-pop cycle of ADD.
        n_checks++;
        if (stk_pop !== 1'b1) begin
            n_fail++;
            $display("FAIL rdb_reached: pop=%b want 1", stk_pop);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stk_push, stk_pop, stk_tos, busy, done} !== 5'b0 || depth !== 6'd0) begin
            n_fail++;
            $display("FAIL midop_reset: ctl=%b depth=%0d want 00000 0",
                     {stk_push, stk_pop, stk_tos, busy, done}, depth);
        end
        rst = 1'b0;
        @(negedge clk);
        d0 = tot_done; p0 = tot_push;
        start = 1'b1; opcode = 3'b000; imm = 8'h55;
        @(negedge clk);
        imm = 8'h66;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (tot_done - d0 !== 1 || tot_push - p0 !== 1 || depth !== 6'd1 || result !== 8'h55) begin
            n_fail++;
            $display("FAIL busy_start: dones=%0d pushes=%0d depth=%0d res=%h want 1 1 1 55",
                     tot_done - d0, tot_push - p0, depth, result);
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_sub();
        test_add_and();
        test_unary();
        test_underflow();
        test_overflow();
        test_midop_reset_and_busy_start();
        n_checks++;
        if (tot_multi !== 0) begin
            n_fail++;
            $display("FAIL strobe_onehot: cycles with multiple strobes=%0d want 0", tot_multi);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
